// File: rtl/vscpu_ram_arbiter.sv
// vscpu_ram_arbiter
// Shares one single-port block RAM (registered read, 1-cycle latency, 32-bit
// data) between two requesters: port 0 (VerySimpleCPU core) and port 1
// (host/debug loader). At most one access is issued per cycle. The grant is
// combinational from req and arbiter state, and read data is steered back to
// the issuing port one cycle after its grant.
//
// Build option:
//   ARB_FIXED_PRIO_EN  - defined: port 0 has fixed priority, and port 1 is
//                        force-granted after MAX_WAIT consecutive denied cycles.
//                        Undefined (default): round-robin between the ports.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   pN_req/we/addr/wdata     port N request, write flag, word address, write data
//   pN_gnt                   port N access issued to RAM this cycle
//   pN_rvalid/rdata          port N read data return (rdata is 0 when not valid)
//   wrEn/addr_toRAM/data_toRAM  RAM command
//   data_fromRAM             RAM registered read data
module vscpu_ram_arbiter #(
  parameter int SIZE     = 14,
  parameter int MAX_WAIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p0_req,
  input  logic            p0_we,
  input  logic [SIZE-1:0] p0_addr,
  input  logic [31:0]     p0_wdata,
  output logic            p0_gnt,
  output logic            p0_rvalid,
  output logic [31:0]     p0_rdata,
  input  logic            p1_req,
  input  logic            p1_we,
  input  logic [SIZE-1:0] p1_addr,
  input  logic [31:0]     p1_wdata,
  output logic            p1_gnt,
  output logic            p1_rvalid,
  output logic [31:0]     p1_rdata,
  output logic            wrEn,
  output logic [SIZE-1:0] addr_toRAM,
  output logic [31:0]     data_toRAM,
  input  logic [31:0]     data_fromRAM
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_max_wait_range
    $error("vscpu_ram_arbiter: MAX_WAIT must be within 1..255");
  end

  // Raw grants feed the state registers; outputs use the reset-gated copies
  // so reset only appears on the output path, never in a flop's data input.
  logic            gr0;
  logic            gr1;
  logic            any_gr;
  logic            sel_we;
  logic [SIZE-1:0] sel_addr;
  logic [31:0]     sel_wdata;

  logic            rd_tag_valid;
  port_e           rd_tag;
  logic [SIZE-1:0] addr_q;
  logic [31:0]     data_q;

`ifdef ARB_FIXED_PRIO_EN
  logic [7:0] wait_cnt;
  logic       aged;

  always_comb begin
    aged = (wait_cnt == 8'(MAX_WAIT));
    gr1  = p1_req && (!p0_req || aged);
    gr0  = p0_req && !gr1;
  end

  // Counts consecutive cycles in which port 1 asks but is refused.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!p1_req || gr1) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  port_e rr_ptr;

  always_comb begin
    gr0 = p0_req && (!p1_req || rr_ptr == PORT0);
    gr1 = p1_req && !gr0;
  end

  // Pointer moves to the other port after a grant; idle cycles leave it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= PORT0;
    end else if (gr0) begin
      rr_ptr <= PORT1;
    end else if (gr1) begin
      rr_ptr <= PORT0;
    end
  end
`endif

  always_comb begin
    any_gr    = gr0 | gr1;
    sel_we    = gr1 ? p1_we    : p0_we;
    sel_addr  = gr1 ? p1_addr  : p0_addr;
    sel_wdata = gr1 ? p1_wdata : p0_wdata;
  end

  always_comb begin
    p0_gnt = gr0 & rst;
    p1_gnt = gr1 & rst;
    // Without a grant the address/data buses hold their last granted value.
    if (p0_gnt || p1_gnt) begin
      wrEn       = sel_we;
      addr_toRAM = sel_addr;
      data_toRAM = sel_wdata;
    end else begin
      wrEn       = 1'b0;
      addr_toRAM = addr_q;
      data_toRAM = data_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_tag_valid <= 1'b0;
      rd_tag       <= PORT0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      rd_tag_valid <= any_gr && !sel_we;
      if (any_gr) begin
        rd_tag <= gr1 ? PORT1 : PORT0;
        addr_q <= sel_addr;
        data_q <= sel_wdata;
      end
    end
  end

  always_comb begin
    p0_rvalid = rd_tag_valid && (rd_tag == PORT0);
    p1_rvalid = rd_tag_valid && (rd_tag == PORT1);
    p0_rdata  = p0_rvalid ? data_fromRAM : '0;
    p1_rdata  = p1_rvalid ? data_fromRAM : '0;
  end

endmodule

// File: tb/tb_vscpu_ram_arbiter.sv
// Bench for vscpu_ram_arbiter: behavioural RAM, table of hand-computed
// vectors, sequences for reset/contention, and randomized traffic checked
// against a transaction-level reference model.
module tb_vscpu_ram_arbiter;
  localparam int SIZE     = 14;
  localparam int MAX_WAIT = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            p0_req = 1'b0, p0_we = 1'b0;
  logic [SIZE-1:0] p0_addr = '0;
  logic [31:0]     p0_wdata = '0;
  logic            p1_req = 1'b0, p1_we = 1'b0;
  logic [SIZE-1:0] p1_addr = '0;
  logic [31:0]     p1_wdata = '0;
  logic            p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0]     p0_rdata, p1_rdata;
  logic            wrEn;
  logic [SIZE-1:0] addr_toRAM;
  logic [31:0]     data_toRAM;
  logic [31:0]     data_fromRAM = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vscpu_ram_arbiter #(.SIZE(SIZE), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .wrEn(wrEn), .addr_toRAM(addr_toRAM), .data_toRAM(data_toRAM),
    .data_fromRAM(data_fromRAM)
  );

  // Single-port RAM with registered read.
  logic [31:0] ram [int];
  always @(posedge clk) begin
    logic [31:0] rd;
    rd = ram.exists(int'(addr_toRAM)) ? ram[int'(addr_toRAM)] : 32'h0;
    if (wrEn) ram[int'(addr_toRAM)] = data_toRAM;
    data_fromRAM <= rd;
  end

  // Reference model: memory contents, tie preference, denial streak of
  // port 1, the read awaiting return, and the last issued address/data.
  logic [31:0]     m_mem [int];
  int              m_prefer;
  int              m_wait;
  bit              m_pend;
  int              m_pend_port;
  logic [31:0]     m_pend_data;
  logic [SIZE-1:0] m_last_addr;
  logic [31:0]     m_last_data;

  task automatic model_reset();
    m_prefer    = 0;
    m_wait      = 0;
    m_pend      = 1'b0;
    m_pend_port = 0;
    m_pend_data = '0;
    m_last_addr = '0;
    m_last_data = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [SIZE-1:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1,
                       input logic [SIZE-1:0] a1, input logic [31:0] d1);
    @(negedge clk);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    #1;
  endtask

  // Compare DUT outputs for the current cycle with the model, then advance
  // the model past the coming rising edge. winner is -1 when nothing issues.
  task automatic check_cycle(input string tag, output int winner);
    int              w;
    logic            ev0, ev1, ewe;
    logic [SIZE-1:0] ea;
    logic [31:0]     ed;
    w = -1;
    if (p0_req && p1_req) begin
`ifdef ARB_FIXED_PRIO_EN
      w = (m_wait >= MAX_WAIT) ? 1 : 0;
`else
      w = m_prefer;
`endif
    end else if (p0_req) w = 0;
    else if (p1_req) w = 1;

    ev0 = m_pend && m_pend_port == 0;
    ev1 = m_pend && m_pend_port == 1;
    ewe = (w == 0) ? p0_we : (w == 1) ? p1_we : 1'b0;
    ea  = (w == 0) ? p0_addr : (w == 1) ? p1_addr : m_last_addr;
    ed  = (w == 0) ? p0_wdata : (w == 1) ? p1_wdata : m_last_data;

    chk({tag, "_p0_gnt"}, p0_gnt, w == 0);
    chk({tag, "_p1_gnt"}, p1_gnt, w == 1);
    chk({tag, "_wrEn"}, wrEn, ewe);
    chk({tag, "_addr"}, addr_toRAM, ea);
    chk({tag, "_wdata"}, data_toRAM, ed);
    chk({tag, "_p0_rvalid"}, p0_rvalid, ev0);
    chk({tag, "_p1_rvalid"}, p1_rvalid, ev1);
    chk({tag, "_p0_rdata"}, p0_rdata, ev0 ? m_pend_data : 32'h0);
    chk({tag, "_p1_rdata"}, p1_rdata, ev1 ? m_pend_data : 32'h0);

    m_pend = 1'b0;
    if (w >= 0) begin
      if (ewe) m_mem[int'(ea)] = ed;
      else begin
        m_pend      = 1'b1;
        m_pend_port = w;
        m_pend_data = m_mem.exists(int'(ea)) ? m_mem[int'(ea)] : 32'h0;
      end
      m_last_addr = ea;
      m_last_data = ed;
      m_prefer    = 1 - w;
    end
    if (!p1_req || w == 1) m_wait = 0;
    else m_wait++;
    winner = w;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_p0_gnt"}, p0_gnt, 1'b0);
    chk({tag, "_p1_gnt"}, p1_gnt, 1'b0);
    chk({tag, "_p0_rvalid"}, p0_rvalid, 1'b0);
    chk({tag, "_p1_rvalid"}, p1_rvalid, 1'b0);
    chk({tag, "_wrEn"}, wrEn, 1'b0);
    chk({tag, "_addr"}, addr_toRAM, 32'h0);
    chk({tag, "_wdata"}, data_toRAM, 32'h0);
  endtask

  typedef struct {
    logic            r0, w0;
    logic [SIZE-1:0] a0;
    logic [31:0]     d0;
    logic            r1, w1;
    logic [SIZE-1:0] a1;
    logic [31:0]     d1;
    logic            g0, g1, we, v0, v1;
    logic [31:0]     q0, q1;
  } vec_t;

  function automatic vec_t mk(input logic r0, w0, input int a0, input logic [31:0] d0,
                              input logic r1, w1, input int a1, input logic [31:0] d1,
                              input logic g0, g1, we, v0, input logic [31:0] q0,
                              input logic v1, input logic [31:0] q1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = SIZE'(a0); v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = SIZE'(a1); v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.we = we; v.v0 = v0; v.q0 = q0; v.v1 = v1; v.q1 = q1;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   w;
    bit   h0, h1;
    logic hw0, hw1;
    logic [SIZE-1:0] ha0, ha1;
    logic [31:0]     hd0, hd1;

    model_reset();

    // Reset held with both ports requesting: everything quiet.
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 14'd5; p0_wdata = 32'hA5A5_0001;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 14'd9; p1_wdata = 32'h0;
    repeat (3) begin
      @(negedge clk); #1;
      chk_reset("in_reset");
    end
    @(negedge clk);
    p0_req = 1'b0; p1_req = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check_cycle("idle", w);
    end

    //            r0 w0 a0   d0            r1 w1 a1   d1            g0 g1 we v0 q0     v1 q1
    tbl.push_back(mk(0, 0, 0,   0,            0, 0, 0,   0,            0, 0, 0, 0, 0,     0, 0));
    tbl.push_back(mk(0, 0, 0,   0,            1, 1, 0,   32'h20114045, 0, 1, 1, 0, 0,     0, 0));
    tbl.push_back(mk(0, 0, 0,   0,            1, 1, 100, 32'h6,        0, 1, 1, 0, 0,     0, 0));
    tbl.push_back(mk(0, 0, 0,   0,            1, 0, 100, 0,            0, 1, 0, 0, 0,     0, 0));
    tbl.push_back(mk(0, 0, 0,   0,            0, 0, 0,   0,            0, 0, 0, 0, 0,     1, 32'h6));
    tbl.push_back(mk(1, 1, 69,  32'h1,        0, 0, 0,   0,            1, 0, 1, 0, 0,     0, 0));
    tbl.push_back(mk(0, 0, 0,   0,            1, 1, 70,  32'h3E8,      0, 1, 1, 0, 0,     0, 0));
`ifdef ARB_FIXED_PRIO_EN
    tbl.push_back(mk(1, 0, 69,  0,            1, 0, 70,  0,            1, 0, 0, 0, 0,     0, 0));
    tbl.push_back(mk(1, 0, 69,  0,            1, 0, 70,  0,            1, 0, 0, 1, 32'h1, 0, 0));
    tbl.push_back(mk(1, 0, 69,  0,            1, 0, 70,  0,            1, 0, 0, 1, 32'h1, 0, 0));
`else
    tbl.push_back(mk(1, 0, 69,  0,            1, 0, 70,  0,            1, 0, 0, 0, 0,     0, 0));
    tbl.push_back(mk(1, 0, 69,  0,            1, 0, 70,  0,            0, 1, 0, 1, 32'h1, 0, 0));
    tbl.push_back(mk(1, 0, 69,  0,            1, 0, 70,  0,            1, 0, 0, 0, 0,     1, 32'h3E8));
`endif
    tbl.push_back(mk(0, 0, 0,   0,            1, 0, 70,  0,            0, 1, 0, 1, 32'h1, 0, 0));
    tbl.push_back(mk(1, 1, 73,  32'hB,        0, 0, 0,   0,            1, 0, 1, 0, 0,     1, 32'h3E8));
    tbl.push_back(mk(0, 0, 0,   0,            1, 0, 73,  0,            0, 1, 0, 0, 0,     0, 0));
    tbl.push_back(mk(0, 0, 0,   0,            0, 0, 0,   0,            0, 0, 0, 0, 0,     1, 32'hB));
    tbl.push_back(mk(1, 0, 73,  0,            0, 0, 0,   0,            1, 0, 0, 0, 0,     0, 0));
`ifdef ARB_FIXED_PRIO_EN
    tbl.push_back(mk(1, 1, 200, 32'hDEAD,     1, 0, 100, 0,            1, 0, 1, 1, 32'hB, 0, 0));
    tbl.push_back(mk(0, 0, 0,   0,            0, 0, 0,   0,            0, 0, 0, 0, 0,     0, 0));
`else
    tbl.push_back(mk(1, 1, 200, 32'hDEAD,     1, 0, 100, 0,            0, 1, 0, 1, 32'hB, 0, 0));
    tbl.push_back(mk(0, 0, 0,   0,            0, 0, 0,   0,            0, 0, 0, 0, 0,     1, 32'h6));
`endif
    tbl.push_back(mk(1, 0, 69,  0,            1, 0, 70,  0,            1, 0, 0, 0, 0,     0, 0));
    tbl.push_back(mk(0, 0, 0,   0,            0, 0, 0,   0,            0, 0, 0, 1, 32'h1, 0, 0));

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      check_cycle({t, "_model"}, w);
      chk({t, "_g0"}, p0_gnt, tbl[i].g0);
      chk({t, "_g1"}, p1_gnt, tbl[i].g1);
      chk({t, "_wrEn"}, wrEn, tbl[i].we);
      chk({t, "_v0"}, p0_rvalid, tbl[i].v0);
      chk({t, "_q0"}, p0_rdata, tbl[i].q0);
      chk({t, "_v1"}, p1_rvalid, tbl[i].v1);
      chk({t, "_q1"}, p1_rdata, tbl[i].q1);
    end

    // Reset lands while a read is in flight: its return is discarded.
    drive(1, 0, 69, 0, 0, 0, 0, 0);
    check_cycle("inflight", w);
    @(posedge clk); #1;
    rst = 1'b0;
    p0_req = 1'b0; p1_req = 1'b0;
    #1;
    chk("midreset_p0_rvalid", p0_rvalid, 1'b0);
    chk("midreset_p0_rdata", p0_rdata, 32'h0);
    chk("midreset_addr", addr_toRAM, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check_cycle("post_reset", w);
    end

    // Continuous contention from a fresh reset.
    for (int i = 0; i < 27; i++) begin
      logic exp1;
`ifdef ARB_FIXED_PRIO_EN
      exp1 = (i % 9) == 8;
`else
      exp1 = (i % 2) == 1;
`endif
      drive(1, 0, 69, 0, 1, 0, 70, 0);
      chk($sformatf("contend%0d_g1", i), p1_gnt, exp1);
      chk($sformatf("contend%0d_g0", i), p0_gnt, !exp1);
      check_cycle("contend", w);
    end

    // Randomized traffic; pending requests hold until granted or withdrawn.
    h0 = 0; h1 = 0;
    hw0 = 0; hw1 = 0; ha0 = '0; ha1 = '0; hd0 = '0; hd1 = '0;
    for (int i = 0; i < 600; i++) begin
      if (!h0) begin
        if ($urandom_range(0, 99) < 60) begin
          h0 = 1; hw0 = $urandom_range(0, 1) == 1;
          ha0 = SIZE'($urandom_range(0, 15)); hd0 = $urandom;
        end
      end else if ($urandom_range(0, 99) < 5) h0 = 0;
      if (!h1) begin
        if ($urandom_range(0, 99) < 60) begin
          h1 = 1; hw1 = $urandom_range(0, 1) == 1;
          ha1 = SIZE'($urandom_range(0, 15)); hd1 = $urandom;
        end
      end else if ($urandom_range(0, 99) < 5) h1 = 0;
      drive(h0, hw0, ha0, hd0, h1, hw1, ha1, hd1);
      check_cycle("rand", w);
      if (w == 0) h0 = 0;
      if (w == 1) h1 = 0;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_cycle("drain", w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
